term_rx_sink: RTL and testbench

TERM_RX_SINK -- requirements
Module: term_rx_sink

---
 rtl/term_rx_sink.sv | 148 ++++++++++++++
 tb/tb_term_rx_sink.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/term_rx_sink.sv
// rtl/term_rx_sink.sv - mesh terminal receive sink with address filter, FWFT buffer and counters
//
// Pops packets from a mesh terminal at most once every three cycles and filters
// them on the destination field. A packet is kept when it is addressed to this
// terminal or is a broadcast, and dropped otherwise. Kept packets go into a
// first-word-fall-through buffer that the host reads. Saturating counters track
// accepted, broadcast and misrouted packets.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous reset, active low
//   pndng      mesh terminal has a packet pending
//   data_out   mesh terminal head packet, valid while pndng=1
//   pop        one-cycle pop strobe to the mesh terminal
//   rx_data    head of the receive buffer
//   rx_valid   receive buffer is not empty
//   rx_rd      host read of rx_data
//   full       receive buffer holds fifo_depth packets
//   clr_cnt    synchronous clear of all counters
//   rx_count   accepted packet count
//   bcst_count broadcast packet count
//   err_count  misrouted packet count
// cnt_sat sets the saturation value of the counters. Its default is 16'hFFFF.
module term_rx_sink #(
    parameter int          pckg_sz    = 40,
    parameter int          fifo_depth = 10,
    parameter int          id_row     = 0,
    parameter int          id_column  = 0,
    parameter logic [15:0] cnt_sat    = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng,
    input  logic [pckg_sz-1:0] data_out,
    output logic               pop,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_rd,
    output logic               full,
    input  logic               clr_cnt,
    output logic [15:0]        rx_count,
    output logic [15:0]        bcst_count,
    output logic [15:0]        err_count
);
    localparam int              PW     = $clog2(fifo_depth);
    localparam int              CW     = $clog2(fifo_depth + 1);
    localparam logic [7:0]      OWN_ID = {4'(id_row), 4'(id_column)};
    localparam logic [PW-1:0]   LAST   = PW'(fifo_depth - 1);
    localparam logic [CW-1:0]   DEPTH  = CW'(fifo_depth);

    typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

    state_t             state_q, state_d;
    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic               full_q, full_d;
    logic [15:0]        rx_cnt_q, rx_cnt_d, bc_cnt_q, bc_cnt_d, er_cnt_q, er_cnt_d;
    logic [7:0]         dest;
    logic               is_bcst, is_mine, in_pop, do_push, do_read;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c >= cnt_sat) ? c : c + 16'd1;
    endfunction

    assign dest    = data_out[pckg_sz-9 -: 8];
    assign is_bcst = (dest == 8'hFF);
    assign is_mine = (dest == OWN_ID);
    assign in_pop  = (state_q == POP);
    // The capture happens on the edge that ends the POP cycle.
    assign do_push = in_pop && (is_bcst || is_mine);
    assign do_read = rx_rd && (occ_q != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pndng && !full_q) state_d = POP;
            POP:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_read ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        if (do_push && !do_read)
            occ_d = occ_q + 1'b1;
        else if (!do_push && do_read)
            occ_d = occ_q - 1'b1;
        full_d = (occ_d == DEPTH);

        rx_cnt_d = rx_cnt_q;
        bc_cnt_d = bc_cnt_q;
        er_cnt_d = er_cnt_q;
        if (clr_cnt) begin
            rx_cnt_d = '0;
            bc_cnt_d = '0;
            er_cnt_d = '0;
        end else if (in_pop) begin
            if (is_bcst || is_mine) rx_cnt_d = sat_inc(rx_cnt_q);
            if (is_bcst)            bc_cnt_d = sat_inc(bc_cnt_q);
            if (!(is_bcst || is_mine)) er_cnt_d = sat_inc(er_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            rx_cnt_q <= '0;
            bc_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            rx_cnt_q <= rx_cnt_d;
            bc_cnt_q <= bc_cnt_d;
            er_cnt_q <= er_cnt_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (reset && do_push)
            mem_q[wr_ptr_q] <= data_out;
    end

    assign pop        = in_pop;
    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_valid   = (occ_q != '0);
    assign full       = full_q;
    assign rx_count   = rx_cnt_q;
    assign bcst_count = bc_cnt_q;
    assign err_count  = er_cnt_q;
endmodule

// File: tb/tb_term_rx_sink.sv
// tb/tb_term_rx_sink.sv - randomized and directed self-checking bench for term_rx_sink
module tb_term_rx_sink;
    localparam int         PK    = 40;
    localparam int         DEPTH = 10;
    localparam logic [7:0] OWN   = 8'h12;
    localparam int         SAT   = 20;

    logic          clk, rst_n, pndng, rx_rd, clr_cnt;
    logic [PK-1:0] data_out;
    logic          pop, rx_valid, full;
    logic [PK-1:0] rx_data;
    logic [15:0]   rx_count, bcst_count, err_count;
    logic          s_pop, s_rx_valid, s_full;
    logic [PK-1:0] s_rx_data;
    logic [15:0]   s_rx_count, s_bcst_count, s_err_count;

    term_rx_sink #(.pckg_sz(PK), .fifo_depth(DEPTH), .id_row(1), .id_column(2)) dut (
        .clk(clk), .reset(rst_n), .pndng(pndng), .data_out(data_out), .pop(pop),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd), .full(full),
        .clr_cnt(clr_cnt), .rx_count(rx_count), .bcst_count(bcst_count), .err_count(err_count));

    // Same stimulus, low saturation point so counter saturation is reachable quickly.
    term_rx_sink #(.pckg_sz(PK), .fifo_depth(DEPTH), .id_row(1), .id_column(2),
                   .cnt_sat(16'(SAT))) dut_sat (
        .clk(clk), .reset(rst_n), .pndng(pndng), .data_out(data_out), .pop(s_pop),
        .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_rd(rx_rd), .full(s_full),
        .clr_cnt(clr_cnt), .rx_count(s_rx_count), .bcst_count(s_bcst_count),
        .err_count(s_err_count));

    int n_cmp = 0;
    int n_err = 0;
    int pop_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffer as a queue, counters as unbounded integers,
    // pop allowed only when neither of the two previous cycles popped.
    logic [PK-1:0] mq[$];
    bit  m_pop = 0, m_prev = 0, armed = 0;
    int  m_rx = 0, m_bc = 0, m_er = 0;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk) begin
        bit p, full_pre, push, i_rx, i_bc, i_er;
        logic [7:0] d;
        if (!rst_n) begin
            mq.delete();
            m_pop = 0; m_prev = 0;
            m_rx = 0; m_bc = 0; m_er = 0;
            armed = 1;
        end else begin
            p = m_pop;
            full_pre = (mq.size() == DEPTH);
            push = 0; i_rx = 0; i_bc = 0; i_er = 0;
            if (p) begin
                d = data_out[PK-9 -: 8];
                if (d == 8'hFF)     begin push = 1; i_rx = 1; i_bc = 1; end
                else if (d == OWN)  begin push = 1; i_rx = 1; end
                else                i_er = 1;
            end
            if (rx_rd && mq.size() > 0) void'(mq.pop_front());
            if (push) mq.push_back(data_out);
            if (clr_cnt) begin
                m_rx = 0; m_bc = 0; m_er = 0;
            end else begin
                m_rx += int'(i_rx); m_bc += int'(i_bc); m_er += int'(i_er);
            end
            m_pop  = pndng && !full_pre && !p && !m_prev;
            m_prev = p;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("pop", 64'(pop), 64'(m_pop));
            chk("rx_valid", 64'(rx_valid), 64'(mq.size() > 0));
            chk("full", 64'(full), 64'(mq.size() == DEPTH));
            if (mq.size() > 0) chk("rx_data", 64'(rx_data), 64'(mq[0]));
            chk("rx_count", 64'(rx_count), 64'(sat(m_rx, 65535)));
            chk("bcst_count", 64'(bcst_count), 64'(sat(m_bc, 65535)));
            chk("err_count", 64'(err_count), 64'(sat(m_er, 65535)));
            chk("sat_rx_count", 64'(s_rx_count), 64'(sat(m_rx, SAT)));
            chk("sat_bcst_count", 64'(s_bcst_count), 64'(sat(m_bc, SAT)));
            chk("sat_err_count", 64'(s_err_count), 64'(sat(m_er, SAT)));
            if (pop) pop_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [PK-1:0] mk_pkt(input logic [7:0] dst);
        logic [63:0] r;
        logic [PK-1:0] p;
        r = {$urandom(), $urandom()};
        p = r[PK-1:0];
        p[PK-9 -: 8] = dst;
        return p;
    endfunction

    function automatic logic [7:0] rand_dest();
        int c;
        c = $urandom_range(0, 3);
        if (c == 0) return 8'hFF;
        if (c == 1) return 8'($urandom());
        return OWN;
    endfunction

    task automatic wait_pop();
        int k;
        k = 0;
        while (pop !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        if (k >= 30) chk("pop_wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_one(input logic [PK-1:0] pkt);
        pndng = 1'b1;
        data_out = pkt;
        wait_pop();
        tick();
        pndng = 1'b0;
    endtask

    task automatic run_held(input int n);
        bit prev;
        for (int i = 0; i < n; i++) begin
            prev = pop;
            tick();
            if (prev) data_out = mk_pkt(OWN);
        end
    endtask

    initial begin
        logic [PK-1:0] pk1, pkb;
        int base;
        bit prev;
        rst_n = 1'b0; pndng = 1'b0; rx_rd = 1'b0; clr_cnt = 1'b0; data_out = '0;
        repeat (3) tick();
        chk("reset_pop", 64'(pop), 64'd0);
        chk("reset_rx_valid", 64'(rx_valid), 64'd0);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_rx_count", 64'(rx_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // Matching packet
        pk1 = mk_pkt(OWN);
        send_one(pk1);
        tick();
        chk("m1_rx_valid", 64'(rx_valid), 64'd1);
        chk("m1_rx_data", 64'(rx_data), 64'(pk1));
        chk("m1_rx_count", 64'(rx_count), 64'd1);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;

        // Broadcast then misrouted 3/3
        pkb = mk_pkt(8'hFF);
        send_one(pkb);
        send_one(mk_pkt(8'h33));
        tick();
        chk("b_rx_count", 64'(rx_count), 64'd2);
        chk("b_bcst_count", 64'(bcst_count), 64'd1);
        chk("b_err_count", 64'(err_count), 64'd1);
        chk("b_rx_data", 64'(rx_data), 64'(pkb));
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        repeat (3) tick();

        // Fill to full with pndng held
        base = pop_cnt;
        pndng = 1'b1;
        data_out = mk_pkt(OWN);
        run_held(60);
        chk("fill_pops", 64'(pop_cnt - base), 64'd10);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_pop_low", 64'(pop), 64'd0);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        run_held(15);
        chk("fill_one_more", 64'(pop_cnt - base), 64'd11);
        pndng = 1'b0;
        rx_rd = 1'b1;
        repeat (12) tick();
        rx_rd = 1'b0;
        chk("drain_empty", 64'(rx_valid), 64'd0);

        // Continuous streaming with a read every cycle
        base = pop_cnt;
        pndng = 1'b1; rx_rd = 1'b1;
        run_held(60);
        chk("stream_pops", 64'(pop_cnt - base), 64'd20);
        chk("stream_not_full", 64'(full), 64'd0);
        pndng = 1'b0;
        repeat (3) tick();
        rx_rd = 1'b0;

        // Reset during POP
        send_one(mk_pkt(OWN));
        pndng = 1'b1; data_out = mk_pkt(OWN);
        wait_pop();
        rst_n = 1'b0; tick(); rst_n = 1'b1; pndng = 1'b0; tick();
        chk("rstpop_rx_valid", 64'(rx_valid), 64'd0);
        chk("rstpop_rx_count", 64'(rx_count), 64'd0);
        chk("rstpop_pop", 64'(pop), 64'd0);

        // Clear coincident with an increment
        pndng = 1'b1; data_out = mk_pkt(OWN);
        wait_pop();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0; pndng = 1'b0; tick();
        chk("clr_rx_count", 64'(rx_count), 64'd0);
        chk("clr_buffer_kept", 64'(rx_valid), 64'd1);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;

        // Saturation
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        rx_rd = 1'b1;
        repeat (25) send_one(mk_pkt(OWN));
        tick();
        chk("sat_held", 64'(s_rx_count), 64'(SAT));
        chk("sat_main", 64'(rx_count), 64'd25);
        rx_rd = 1'b0;

        // Random traffic
        data_out = mk_pkt(rand_dest());
        for (int i = 0; i < 1500; i++) begin
            pndng   = ($urandom_range(0, 3) != 0);
            rx_rd   = ($urandom_range(0, 1) != 0);
            clr_cnt = ($urandom_range(0, 99) < 3);
            rst_n   = ($urandom_range(0, 199) != 0);
            prev = pop;
            tick();
            if (prev || $urandom_range(0, 9) == 0) data_out = mk_pkt(rand_dest());
        end
        rst_n = 1'b1; pndng = 1'b0; rx_rd = 1'b0; clr_cnt = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
